// File: rtl/mem_arb_pkg.sv
// Purpose : shared types and constants for the I/D cache memory-port arbiter.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package mem_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_RD,
        WAIT_WR,
        RESP
    } arb_state_t;

    // Bit position in the pending vector follows this encoding.
    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } arb_port_t;

    // Lines are 64-byte aligned downstream.
    localparam logic [63:0] LINE_MASK = 64'hffff_ffff_ffff_ffc0;

endpackage

// File: rtl/rr_arbiter2.sv
// Purpose : two-way round-robin pick; a sole requester wins, a tie goes to the one not served last.
// Latency : combinational.
// Backpressure: none; the caller decides when to consume the grant.
// Ports   : pending[1:0] requesters, rr_last last served index -> grant index, valid = any pending.
module rr_arbiter2 (
    input  logic [1:0] pending,
    input  logic       rr_last,
    output logic       grant,
    output logic       valid
);

    always_comb begin
        valid = |pending;
        case (pending)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            default: grant = ~rr_last;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Purpose : shares one memory-controller port between I-cache and D-cache, one transaction at a time;
//           also re-broadcasts controller invalidations to both caches.
// Latency : req -> mc_req 2 cycles; mc_rvalid/mc_wdone -> *_mem_data_valid 1 cycle; mc_inval -> pulse 1 cycle.
// Backpressure: mc_req and its fields hold until mc_accept; a cache request is dropped while that port
//           is already pending or owns the in-flight transaction.
// Ports   : i_* / d_* cache sides, mc_* controller side, cache_invalid_bit* invalidation broadcast.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int BLOCKSZ     = 512,
    parameter int ADDRESSSIZE = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_mem_req,
    input  logic                   i_mem_wr_en,
    input  logic [ADDRESSSIZE-1:0] i_mem_address,
    input  logic [BLOCKSZ-1:0]     i_mem_data_out,
    output logic [BLOCKSZ-1:0]     i_mem_data_in,
    output logic                   i_mem_data_valid,
    input  logic                   d_mem_req,
    input  logic                   d_mem_wr_en,
    input  logic [ADDRESSSIZE-1:0] d_mem_address,
    input  logic [BLOCKSZ-1:0]     d_mem_data_out,
    output logic [BLOCKSZ-1:0]     d_mem_data_in,
    output logic                   d_mem_data_valid,
    output logic                   mc_req,
    output logic                   mc_wr_en,
    output logic [ADDRESSSIZE-1:0] mc_addr,
    output logic [BLOCKSZ-1:0]     mc_wdata,
    input  logic                   mc_accept,
    input  logic                   mc_rvalid,
    input  logic [BLOCKSZ-1:0]     mc_rdata,
    input  logic                   mc_wdone,
    input  logic                   mc_inval,
    input  logic [63:0]            mc_inval_addr,
    output logic                   cache_invalid_bit,
    output logic [63:0]            cache_invalid_bit_addr
);

    // Built from the low-bit complement so it stays correct for any address width.
    localparam logic [ADDRESSSIZE-1:0] ADDR_MASK = ~ADDRESSSIZE'(~LINE_MASK);

    typedef struct packed {
        logic                   wr_en;
        logic [ADDRESSSIZE-1:0] addr;
        logic [BLOCKSZ-1:0]     wdata;
    } req_lat_t;

    arb_state_t             state_q, state_d;
    arb_port_t              owner_q, owner_d;
    arb_port_t              rr_last_q, rr_last_d;
    logic [1:0]             pend_q, pend_d;
    req_lat_t               i_lat_q, i_lat_d, d_lat_q, d_lat_d;
    logic                   mc_req_q, mc_req_d;
    logic                   mc_wr_en_q, mc_wr_en_d;
    logic [ADDRESSSIZE-1:0] mc_addr_q, mc_addr_d;
    logic [BLOCKSZ-1:0]     mc_wdata_q, mc_wdata_d;
    logic [BLOCKSZ-1:0]     i_data_q, i_data_d, d_data_q, d_data_d;
    logic                   i_vld_q, i_vld_d, d_vld_q, d_vld_d;
    logic                   inval_q, inval_d;
    logic [63:0]            inval_addr_q, inval_addr_d;

    logic                   grant_raw;
    logic                   grant_vld;
    arb_port_t              grant;
    req_lat_t               sel;
    logic                   busy;

    rr_arbiter2 u_rr (
        .pending (pend_q),
        .rr_last (rr_last_q),
        .grant   (grant_raw),
        .valid   (grant_vld)
    );

    assign grant = arb_port_t'(grant_raw);

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        rr_last_d    = rr_last_q;
        pend_d       = pend_q;
        i_lat_d      = i_lat_q;
        d_lat_d      = d_lat_q;
        mc_req_d     = mc_req_q;
        mc_wr_en_d   = mc_wr_en_q;
        mc_addr_d    = mc_addr_q;
        mc_wdata_d   = mc_wdata_q;
        i_data_d     = i_data_q;
        d_data_d     = d_data_q;
        i_vld_d      = 1'b0;
        d_vld_d      = 1'b0;
        inval_d      = mc_inval;
        inval_addr_d = mc_inval ? mc_inval_addr : inval_addr_q;
        sel          = (grant == PORT_I) ? i_lat_q : d_lat_q;

        // The owner stays "busy" from ISSUE through RESP, so a held request
        // cannot re-arm until its own transaction has fully completed.
        busy = (state_q != IDLE);

        if (i_mem_req && !pend_q[PORT_I] && !(busy && owner_q == PORT_I)) begin
            pend_d[PORT_I] = 1'b1;
            i_lat_d.wr_en  = i_mem_wr_en;
            i_lat_d.addr   = i_mem_address & ADDR_MASK;
            i_lat_d.wdata  = i_mem_data_out;
        end
        if (d_mem_req && !pend_q[PORT_D] && !(busy && owner_q == PORT_D)) begin
            pend_d[PORT_D] = 1'b1;
            d_lat_d.wr_en  = d_mem_wr_en;
            d_lat_d.addr   = d_mem_address & ADDR_MASK;
            d_lat_d.wdata  = d_mem_data_out;
        end

        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    owner_d    = grant;
                    state_d    = ISSUE;
                    mc_req_d   = 1'b1;
                    mc_wr_en_d = sel.wr_en;
                    mc_addr_d  = sel.addr;
                    mc_wdata_d = sel.wdata;
                end
            end
            ISSUE: begin
                if (mc_accept) begin
                    mc_req_d        = 1'b0;
                    pend_d[owner_q] = 1'b0;
                    rr_last_d       = owner_q;
                    state_d         = mc_wr_en_q ? WAIT_WR : WAIT_RD;
                end
            end
            WAIT_RD: begin
                if (mc_rvalid) begin
                    if (owner_q == PORT_I) begin
                        i_data_d = mc_rdata;
                        i_vld_d  = 1'b1;
                    end else begin
                        d_data_d = mc_rdata;
                        d_vld_d  = 1'b1;
                    end
                    state_d = RESP;
                end
            end
            WAIT_WR: begin
                if (mc_wdone) begin
                    i_vld_d = (owner_q == PORT_I);
                    d_vld_d = (owner_q == PORT_D);
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            owner_q      <= PORT_I;
            rr_last_q    <= PORT_D;
            pend_q       <= '0;
            i_lat_q      <= '0;
            d_lat_q      <= '0;
            mc_req_q     <= 1'b0;
            mc_wr_en_q   <= 1'b0;
            mc_addr_q    <= '0;
            mc_wdata_q   <= '0;
            i_data_q     <= '0;
            d_data_q     <= '0;
            i_vld_q      <= 1'b0;
            d_vld_q      <= 1'b0;
            inval_q      <= 1'b0;
            inval_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            rr_last_q    <= rr_last_d;
            pend_q       <= pend_d;
            i_lat_q      <= i_lat_d;
            d_lat_q      <= d_lat_d;
            mc_req_q     <= mc_req_d;
            mc_wr_en_q   <= mc_wr_en_d;
            mc_addr_q    <= mc_addr_d;
            mc_wdata_q   <= mc_wdata_d;
            i_data_q     <= i_data_d;
            d_data_q     <= d_data_d;
            i_vld_q      <= i_vld_d;
            d_vld_q      <= d_vld_d;
            inval_q      <= inval_d;
            inval_addr_q <= inval_addr_d;
        end
    end

    assign mc_req                 = mc_req_q;
    assign mc_wr_en               = mc_wr_en_q;
    assign mc_addr                = mc_addr_q;
    assign mc_wdata               = mc_wdata_q;
    assign i_mem_data_in          = i_data_q;
    assign d_mem_data_in          = d_data_q;
    assign i_mem_data_valid       = i_vld_q;
    assign d_mem_data_valid       = d_vld_q;
    assign cache_invalid_bit      = inval_q;
    assign cache_invalid_bit_addr = inval_addr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose : directed self-checking bench for mem_arbiter.
// Latency : n/a.
// Backpressure: exercised by holding mc_accept low.
module tb_mem_arbiter;

    logic         clk;
    logic         rst;
    logic         i_mem_req, i_mem_wr_en, d_mem_req, d_mem_wr_en;
    logic [63:0]  i_mem_address, d_mem_address;
    logic [511:0] i_mem_data_out, d_mem_data_out, i_mem_data_in, d_mem_data_in;
    logic         i_mem_data_valid, d_mem_data_valid;
    logic         mc_req, mc_wr_en, mc_accept, mc_rvalid, mc_wdone, mc_inval;
    logic [63:0]  mc_addr, mc_inval_addr, cache_invalid_bit_addr;
    logic [511:0] mc_wdata, mc_rdata;
    logic         cache_invalid_bit;

    int errors = 0;
    int checks = 0;
    int hs_cnt = 0;
    int i_vld_cnt = 0;
    int d_vld_cnt = 0;

    localparam logic [511:0] LINE_AA = {64{8'hAA}};
    localparam logic [511:0] LINE_55 = {64{8'h55}};
    localparam logic [511:0] LINE_3C = {64{8'h3C}};

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .i_mem_req(i_mem_req), .i_mem_wr_en(i_mem_wr_en), .i_mem_address(i_mem_address),
        .i_mem_data_out(i_mem_data_out), .i_mem_data_in(i_mem_data_in), .i_mem_data_valid(i_mem_data_valid),
        .d_mem_req(d_mem_req), .d_mem_wr_en(d_mem_wr_en), .d_mem_address(d_mem_address),
        .d_mem_data_out(d_mem_data_out), .d_mem_data_in(d_mem_data_in), .d_mem_data_valid(d_mem_data_valid),
        .mc_req(mc_req), .mc_wr_en(mc_wr_en), .mc_addr(mc_addr), .mc_wdata(mc_wdata),
        .mc_accept(mc_accept), .mc_rvalid(mc_rvalid), .mc_rdata(mc_rdata), .mc_wdone(mc_wdone),
        .mc_inval(mc_inval), .mc_inval_addr(mc_inval_addr),
        .cache_invalid_bit(cache_invalid_bit), .cache_invalid_bit_addr(cache_invalid_bit_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Event counters sampled on the active edge (pre-update values).
    always @(posedge clk) begin
        if (mc_req && mc_accept) hs_cnt <= hs_cnt + 1;
        if (i_mem_data_valid) i_vld_cnt <= i_vld_cnt + 1;
        if (d_mem_data_valid) d_vld_cnt <= d_vld_cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        i_mem_req = 0; i_mem_wr_en = 0; i_mem_address = '0; i_mem_data_out = '0;
        d_mem_req = 0; d_mem_wr_en = 0; d_mem_address = '0; d_mem_data_out = '0;
        mc_accept = 0; mc_rvalid = 0; mc_rdata = '0; mc_wdone = 0;
        mc_inval = 0; mc_inval_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        logic [511:0] zero512;
        zero512 = '0;
        do_reset();
        checks++;
        if ({mc_req, mc_wr_en, i_mem_data_valid, d_mem_data_valid, cache_invalid_bit} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 00000",
                     {mc_req, mc_wr_en, i_mem_data_valid, d_mem_data_valid, cache_invalid_bit});
        end
        checks++;
        if (mc_addr !== 64'h0 || cache_invalid_bit_addr !== 64'h0) begin
            errors++;
            $display("FAIL reset_addr: got mc_addr=%h inval_addr=%h want 0", mc_addr, cache_invalid_bit_addr);
        end
        checks++;
        if (mc_wdata !== zero512 || i_mem_data_in !== zero512 || d_mem_data_in !== zero512) begin
            errors++;
            $display("FAIL reset_data: wdata/i_in/d_in not zero");
        end
    endtask

    task automatic test_read_i();
        do_reset();
        mc_accept = 1;
        i_mem_req = 1; i_mem_wr_en = 0; i_mem_address = 64'h1048;
        step();
        i_mem_req = 0;
        checks++;
        if (mc_req !== 1'b0) begin
            errors++; $display("FAIL rd_early_req: got %b want 0", mc_req);
        end
        step();
        checks++;
        if (mc_req !== 1'b1 || mc_addr !== 64'h1040 || mc_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL rd_issue: got req=%b addr=%h wr=%b want 1 1040 0", mc_req, mc_addr, mc_wr_en);
        end
        step();
        checks++;
        if (mc_req !== 1'b0) begin
            errors++; $display("FAIL rd_req_drop: got %b want 0", mc_req);
        end
        step(); step();
        mc_rvalid = 1; mc_rdata = LINE_AA;
        checks++;
        if (i_mem_data_valid !== 1'b0) begin
            errors++; $display("FAIL rd_early_valid: got %b want 0", i_mem_data_valid);
        end
        step();
        mc_rvalid = 0; mc_rdata = '0;
        checks++;
        if (i_mem_data_valid !== 1'b1 || d_mem_data_valid !== 1'b0 || i_mem_data_in !== LINE_AA) begin
            errors++;
            $display("FAIL rd_resp: got iv=%b dv=%b data=%h want 1 0 aa..",
                     i_mem_data_valid, d_mem_data_valid, i_mem_data_in);
        end
        step();
        checks++;
        if (i_mem_data_valid !== 1'b0 || i_mem_data_in !== LINE_AA) begin
            errors++; $display("FAIL rd_pulse_hold: got iv=%b data=%h want 0 aa..", i_mem_data_valid, i_mem_data_in);
        end
    endtask

    task automatic test_fairness();
        logic [63:0] got[$];
        logic        resp_next;
        logic [63:0] exp_addr;
        int          cyc;
        do_reset();
        mc_accept = 1;
        i_mem_req = 1; i_mem_wr_en = 0; i_mem_address = 64'h1000;
        d_mem_req = 1; d_mem_wr_en = 0; d_mem_address = 64'h2000;
        resp_next = 0;
        cyc = 0;
        while (got.size() < 4 && cyc < 200) begin
            step();
            cyc++;
            mc_rvalid = resp_next;
            mc_rdata  = LINE_3C;
            resp_next = mc_req;
            if (mc_req) got.push_back(mc_addr);
        end
        i_mem_req = 0; d_mem_req = 0; mc_rvalid = 0;
        checks++;
        if (got.size() != 4) begin
            errors++; $display("FAIL rr_timeout: got %0d grants want 4", got.size());
        end
        for (int k = 0; k < 4; k++) begin
            if (k < got.size()) begin
                exp_addr = (k % 2 == 0) ? 64'h1000 : 64'h2000;
                checks++;
                if (got[k] !== exp_addr) begin
                    errors++; $display("FAIL rr_grant%0d: got %h want %h", k, got[k], exp_addr);
                end
            end
        end
    endtask

    task automatic test_write_stall();
        int base;
        do_reset();
        base = d_vld_cnt;
        d_mem_req = 1; d_mem_wr_en = 1; d_mem_address = 64'h2000; d_mem_data_out = LINE_55;
        step();
        d_mem_req = 0; d_mem_data_out = '0;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (mc_req !== 1'b1 || mc_wr_en !== 1'b1 || mc_addr !== 64'h2000 || mc_wdata !== LINE_55) begin
                errors++;
                $display("FAIL wr_stall%0d: got req=%b wr=%b addr=%h want 1 1 2000", k, mc_req, mc_wr_en, mc_addr);
            end
        end
        mc_accept = 1;
        step();
        mc_accept = 0;
        checks++;
        if (mc_req !== 1'b0) begin
            errors++; $display("FAIL wr_req_drop: got %b want 0", mc_req);
        end
        step();
        mc_wdone = 1;
        step();
        mc_wdone = 0;
        checks++;
        if (d_mem_data_valid !== 1'b1 || i_mem_data_valid !== 1'b0) begin
            errors++; $display("FAIL wr_done: got dv=%b iv=%b want 1 0", d_mem_data_valid, i_mem_data_valid);
        end
        step(); step();
        checks++;
        if (d_vld_cnt - base != 1) begin
            errors++; $display("FAIL wr_pulse_cnt: got %0d want 1", d_vld_cnt - base);
        end
    endtask

    task automatic test_inval();
        do_reset();
        mc_accept = 1;
        i_mem_req = 1; i_mem_wr_en = 0; i_mem_address = 64'h3000;
        step();
        i_mem_req = 0;
        step(); step();
        mc_inval = 1; mc_inval_addr = 64'h8040;
        step();
        mc_inval = 1; mc_inval_addr = 64'h9000;
        mc_rvalid = 1; mc_rdata = LINE_AA;
        checks++;
        if (cache_invalid_bit !== 1'b1 || cache_invalid_bit_addr !== 64'h8040) begin
            errors++;
            $display("FAIL inv_first: got %b %h want 1 8040", cache_invalid_bit, cache_invalid_bit_addr);
        end
        step();
        mc_inval = 0; mc_inval_addr = 64'hdead_0000; mc_rvalid = 0;
        checks++;
        if (cache_invalid_bit !== 1'b1 || cache_invalid_bit_addr !== 64'h9000) begin
            errors++;
            $display("FAIL inv_b2b: got %b %h want 1 9000", cache_invalid_bit, cache_invalid_bit_addr);
        end
        checks++;
        if (i_mem_data_valid !== 1'b1 || i_mem_data_in !== LINE_AA) begin
            errors++; $display("FAIL inv_rd_done: got iv=%b data=%h want 1 aa..", i_mem_data_valid, i_mem_data_in);
        end
        step();
        checks++;
        if (cache_invalid_bit !== 1'b0 || cache_invalid_bit_addr !== 64'h9000) begin
            errors++;
            $display("FAIL inv_hold: got %b %h want 0 9000", cache_invalid_bit, cache_invalid_bit_addr);
        end
    endtask

    task automatic test_reset_mid();
        int base;
        do_reset();
        mc_accept = 1;
        i_mem_req = 1; i_mem_wr_en = 0; i_mem_address = 64'h4000;
        step();
        i_mem_req = 0;
        step(); step();
        rst = 0;
        #1;
        checks++;
        if (mc_req !== 1'b0 || mc_addr !== 64'h0 || i_mem_data_valid !== 1'b0) begin
            errors++; $display("FAIL rstmid_async: got req=%b addr=%h iv=%b want 0 0 0", mc_req, mc_addr, i_mem_data_valid);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1;
        base = i_vld_cnt + d_vld_cnt;
        mc_rvalid = 1; mc_rdata = LINE_AA;
        step();
        mc_rvalid = 0;
        step(); step();
        checks++;
        if (i_vld_cnt + d_vld_cnt != base || mc_req !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_late_rvalid: got pulses=%0d req=%b want 0 0", i_vld_cnt + d_vld_cnt - base, mc_req);
        end
        d_mem_req = 1; d_mem_wr_en = 0; d_mem_address = 64'h5008;
        step();
        d_mem_req = 0;
        step();
        checks++;
        if (mc_req !== 1'b1 || mc_addr !== 64'h5000) begin
            errors++; $display("FAIL rstmid_idle: got req=%b addr=%h want 1 5000", mc_req, mc_addr);
        end
    endtask

    task automatic test_spurious();
        int vbase;
        int hbase;
        do_reset();
        vbase = i_vld_cnt + d_vld_cnt;
        mc_wdone = 1;
        step();
        mc_wdone = 0;
        step(); step();
        checks++;
        if (i_vld_cnt + d_vld_cnt != vbase || mc_req !== 1'b0) begin
            errors++;
            $display("FAIL spur_wdone: got pulses=%0d req=%b want 0 0", i_vld_cnt + d_vld_cnt - vbase, mc_req);
        end
        hbase = hs_cnt;
        mc_accept = 1;
        i_mem_req = 1; i_mem_wr_en = 0; i_mem_address = 64'h6000;
        repeat (10) step();
        i_mem_req = 0;
        step(); step();
        checks++;
        if (hs_cnt - hbase != 1) begin
            errors++; $display("FAIL held_req_count: got %0d transactions want 1", hs_cnt - hbase);
        end
        mc_rvalid = 1; mc_rdata = LINE_55;
        step();
        mc_rvalid = 0;
        checks++;
        if (i_mem_data_valid !== 1'b1 || i_mem_data_in !== LINE_55) begin
            errors++; $display("FAIL held_req_resp: got iv=%b data=%h want 1 55..", i_mem_data_valid, i_mem_data_in);
        end
        repeat (4) step();
        checks++;
        if (hs_cnt - hbase != 1) begin
            errors++; $display("FAIL held_req_after: got %0d transactions want 1", hs_cnt - hbase);
        end
    endtask

    initial begin
        test_reset();
        test_read_i();
        test_fairness();
        test_write_stall();
        test_inval();
        test_reset_mid();
        test_spurious();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
